// File: rtl/reg_dump_unit_if.sv
// reg_dump_unit_if: byte stream towards the debug UART plus the register-file B read port.
interface reg_dump_unit_if #(
    parameter int SEL_WIDTH = 4
);
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [SEL_WIDTH-1:0] rf_select;
    logic [7:0]           rf_data;
    modport master (output tx_data, tx_valid, rf_select, input tx_ready, rf_data);
    modport slave  (input tx_data, tx_valid, rf_select, output tx_ready, rf_data);
endinterface

// File: rtl/reg_dump_unit.sv
// reg_dump_unit: halts the core and streams header, every register and an optional checksum byte.
module reg_dump_unit #(
    parameter int         NUM_REGS      = 16,
    parameter int         SEL_WIDTH     = 4,
    parameter logic [7:0] HEADER        = 8'hA5,
    parameter bit         SEND_CHECKSUM = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            halt_req,
    output logic            busy,
    output logic            done,
    reg_dump_unit_if.master bus
);
    typedef enum logic [2:0] {IDLE, HEADER_S, LOAD, SEND, CKSUM, FINISH} state_t;
    localparam logic [SEL_WIDTH-1:0] LAST = SEL_WIDTH'(NUM_REGS - 1);
    state_t               state_q, state_d;
    logic [7:0]           tx_data_q, tx_data_d, acc_q, acc_d;
    logic                 tx_valid_q, tx_valid_d;
    logic [SEL_WIDTH-1:0] index_q, index_d;
    logic                 xfer;
    assign xfer          = tx_valid_q && bus.tx_ready;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.rf_select = (state_q == LOAD) ? index_q : '0;
    assign busy          = (state_q != IDLE) && (state_q != FINISH);
    assign halt_req      = busy;
    assign done          = (state_q == FINISH);
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            acc_q      <= '0;
            index_q    <= '0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            acc_q      <= acc_d;
            index_q    <= index_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        acc_d      = acc_q;
        index_d    = index_q;
        case (state_q)
            IDLE: if (start) begin
                state_d    = HEADER_S;
                tx_data_d  = HEADER;
                tx_valid_d = 1'b1;
                acc_d      = HEADER;
                index_d    = '0;
            end
            HEADER_S: if (xfer) begin
                state_d    = LOAD;
                tx_valid_d = 1'b0;
            end
            LOAD: begin
                state_d    = SEND;
                tx_data_d  = bus.rf_data;
                acc_d      = acc_q + bus.rf_data;
                tx_valid_d = 1'b1;
            end
            SEND: if (xfer) begin
                tx_valid_d = 1'b0;
                if (index_q != LAST) begin
                    index_d = index_q + SEL_WIDTH'(1);
                    state_d = LOAD;
                end else if (SEND_CHECKSUM) begin
                    // checksum makes the mod-256 sum of the whole frame zero
                    state_d    = CKSUM;
                    tx_data_d  = 8'h00 - acc_q;
                    tx_valid_d = 1'b1;
                end else begin
                    state_d = FINISH;
                end
            end
            CKSUM: if (xfer) begin
                state_d    = FINISH;
                tx_valid_d = 1'b0;
            end
            FINISH: begin
                state_d   = IDLE;
                tx_data_d = '0;
                acc_d     = '0;
                index_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_reg_dump_unit.sv
// tb_reg_dump_unit: table-driven frame checks plus reset/start corner sequences.
module tb_reg_dump_unit;
    typedef struct {
        int         pat;
        int         stall_reg;
        int         stall_len;
        int         restart_reg;
        logic [7:0] exp_ck;
        int         exp_done_a;
        int         exp_done_b;
    } vec_t;
    logic       clk, reset, start, tx_ready;
    logic       halt_a, busy_a, done_a, halt_b, busy_b, done_b;
    logic [7:0] regs [16];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    reg_dump_unit_if #(.SEL_WIDTH(4)) bus_a ();
    reg_dump_unit_if #(.SEL_WIDTH(4)) bus_b ();
    assign bus_a.tx_ready = tx_ready;
    assign bus_b.tx_ready = tx_ready;
    assign bus_a.rf_data  = regs[bus_a.rf_select];
    assign bus_b.rf_data  = regs[bus_b.rf_select];
    reg_dump_unit #(.SEND_CHECKSUM(1'b1)) dut_a (
        .clk(clk), .reset(reset), .start(start),
        .halt_req(halt_a), .busy(busy_a), .done(done_a), .bus(bus_a)
    );
    reg_dump_unit #(.SEND_CHECKSUM(1'b0)) dut_b (
        .clk(clk), .reset(reset), .start(start),
        .halt_req(halt_b), .busy(busy_b), .done(done_b), .bus(bus_b)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask
    function automatic logic [7:0] exp_byte(input int pat, input int n);
        case (pat)
            0: return 8'h00;
            1: return 8'(n);
            2: return 8'hFF;
            default: return 8'(n * 16);
        endcase
    endfunction
    function automatic logic [15:0] idle_vec(input logic v, b, h, d, input logic [7:0] t, input logic [3:0] s);
        return {v, b, h, d, t, s};
    endfunction
    task automatic run_frame(input vec_t v);
        logic [7:0] qa [$];
        logic [7:0] qb [$];
        int s, rel, da, db, nda, ndb, ba, bb, hm, stalled, bm, sum;
        bit restarted;
        da = -1; db = -1; nda = 0; ndb = 0; ba = 0; bb = 0; hm = 0; stalled = 0; bm = 0; sum = 0;
        restarted = 1'b0;
        for (int n = 0; n < 16; n++) regs[n] = exp_byte(v.pat, n);
        @(negedge clk);
        start = 1'b1;
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        s = cyc;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            rel = cyc - s + 1;
            start = 1'b0;
            tx_ready = 1'b1;
            if (v.stall_reg >= 0 && stalled < v.stall_len && bus_a.tx_valid && qa.size() == v.stall_reg + 1) begin
                tx_ready = 1'b0;
                stalled++;
                chk("stall_hold", {bus_a.tx_valid, bus_a.tx_data}, {1'b1, exp_byte(v.pat, v.stall_reg)});
            end
            if (v.restart_reg >= 0 && !restarted && bus_a.tx_valid && qa.size() == v.restart_reg + 1) begin
                start = 1'b1;
                restarted = 1'b1;
            end
            if (bus_a.tx_valid && tx_ready) qa.push_back(bus_a.tx_data);
            if (bus_b.tx_valid && tx_ready) qb.push_back(bus_b.tx_data);
            if (done_a) begin nda++; da = rel; end
            if (done_b) begin ndb++; db = rel; end
            if (busy_a) ba++;
            if (busy_b) bb++;
            if (halt_a !== busy_a || halt_b !== busy_b) hm++;
        end
        start = 1'b0;
        chk("len_a", qa.size(), 18);
        chk("len_b", qb.size(), 17);
        for (int i = 0; i < 17; i++) begin
            logic [7:0] e;
            e = (i == 0) ? 8'hA5 : exp_byte(v.pat, i - 1);
            if (i >= qa.size() || qa[i] !== e) bm++;
            if (i >= qb.size() || qb[i] !== e) bm++;
        end
        chk("frame_bytes_bad", bm, 0);
        chk("cksum_byte", (qa.size() > 17) ? {24'h0, qa[17]} : 32'hDEAD, {24'h0, v.exp_ck});
        foreach (qa[i]) sum += qa[i];
        chk("frame_sum", sum % 256, 0);
        chk("done_cyc_a", da, v.exp_done_a);
        chk("done_cyc_b", db, v.exp_done_b);
        chk("done_cnt_a", nda, 1);
        chk("done_cnt_b", ndb, 1);
        chk("busy_cyc_a", ba, v.exp_done_a - 1);
        chk("busy_cyc_b", bb, v.exp_done_b - 1);
        chk("halt_eq_busy", hm, 0);
    endtask
    initial begin
        vec_t vecs [6];
        int   s;
        vecs[0] = '{0, -1, 0, -1, 8'h5B, 35, 34};
        vecs[1] = '{1, -1, 0, -1, 8'hE3, 35, 34};
        vecs[2] = '{1,  5, 3, -1, 8'hE3, 38, 37};
        vecs[3] = '{1, -1, 0,  3, 8'hE3, 35, 34};
        vecs[4] = '{2, -1, 0, -1, 8'h6B, 35, 34};
        vecs[5] = '{3, -1, 0, -1, 8'hDB, 35, 34};
        for (int n = 0; n < 16; n++) regs[n] = 8'(n);
        reset = 1'b1;
        start = 1'b0;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_a", idle_vec(bus_a.tx_valid, busy_a, halt_a, done_a, bus_a.tx_data, bus_a.rf_select), 0);
        chk("reset_b", idle_vec(bus_b.tx_valid, busy_b, halt_b, done_b, bus_b.tx_data, bus_b.rf_select), 0);
        reset = 1'b0;
        @(negedge clk);
        start = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        chk("start_vs_reset", {busy_a, busy_b, bus_a.tx_valid}, 0);
        @(negedge clk);
        chk("no_queued_start", {busy_a, busy_b}, 0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        s = cyc;
        chk("header_valid", {bus_a.tx_valid, bus_a.tx_data, busy_a, halt_a}, {1'b1, 8'hA5, 1'b1, 1'b1});
        while (cyc - s + 1 < 17) @(negedge clk);
        chk("r7_send", {bus_a.tx_valid, bus_a.tx_data}, {1'b1, 8'h07});
        reset = 1'b1;
        tx_ready = 1'b0;
        @(negedge clk);
        chk("midrst_a", idle_vec(bus_a.tx_valid, busy_a, halt_a, done_a, bus_a.tx_data, bus_a.rf_select), 0);
        chk("midrst_b", idle_vec(bus_b.tx_valid, busy_b, halt_b, done_b, bus_b.tx_data, bus_b.rf_select), 0);
        reset = 1'b0;
        tx_ready = 1'b1;
        @(negedge clk);
        chk("midrst_stay_idle", {busy_a, busy_b, done_a, done_b}, 0);
        for (int i = 0; i < 6; i++) run_frame(vecs[i]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
